exception_ctrl: RTL and testbench
=================================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2: memory read wait cycles, legal range 1..7.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port exc_opcode, input, 1: invalid-opcode event, level, sampled in IDLE.
REQ-005 SHALL have port exc_overflow, input, 1: ALU overflow event, level, sampled in IDLE.
REQ-006 SHALL have port exc_div0, input, 1: divide-by-zero event, level, sampled in IDLE.
REQ-007 SHALL have port pc_in, input, 32: current PC, already incremented by 4.
REQ-008 SHALL have port mem_rdata, input, 32: memory read data; the vector byte is in bits [7:0].
REQ-009 SHALL have port mem_sel, output, 3: selector for the memory-address mux.
REQ-010 SHALL have port epc_wr, output, 1: EPC register write enable.
REQ-011 SHALL have port epc_out, output, 32: value to write into EPC.
REQ-012 SHALL have port pc_wr, output, 1: PC write enable.
REQ-013 SHALL have port pc_out, output, 32: handler address to write into PC.
REQ-014 SHALL have port exc_cause, output, 2: latched cause (01 opcode, 10 overflow, 11 div0, 00 none).
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-016 SHALL implement the states IDLE, SAVE, WAIT and WRITE; all outputs SHALL be registered or decoded from state only (Moore).
REQ-017 IDLE transitions: any exc_* high at an edge -> SAVE; otherwise stay in IDLE.
REQ-018 Priority when events are simultaneous: exc_opcode > exc_overflow > exc_div0; only the winner is latched into exc_cause.
REQ-019 Vector mapping: opcode -> mem_sel 3'b100 (address 253); overflow -> 3'b101 (address 254); div0 -> 3'b110 (address 255).
REQ-020 On the IDLE->SAVE edge: latch epc_out = pc_in - 4, computed modulo 2^32 (pc_in = 0 gives 32'hFFFFFFFC), and latch exc_cause.
REQ-021 In SAVE (exactly 1 cycle): epc_wr = 1 and mem_sel = vector; next state WAIT.
REQ-022 In WAIT (exactly MEM_WAIT cycles, using an internal down-counter): mem_sel = vector and epc_wr = 0.
REQ-023 At the edge ending the last WAIT cycle: pc_out <= {24'b0, mem_rdata[7:0]}; next state WRITE.
REQ-024 In WRITE (exactly 1 cycle): pc_wr = 1 and mem_sel = 3'b000; next state IDLE.
REQ-025 In IDLE: mem_sel = 3'b000, epc_wr = 0, pc_wr = 0; pc_out, epc_out and exc_cause SHALL hold their last values.
REQ-026 exc_* inputs SHALL be ignored while busy; an event still high on return to IDLE SHALL start a new sequence at the next edge.
REQ-027 Latency: event sampled at edge 0 -> SAVE in cycle 1 -> pc_wr high in cycle 2+MEM_WAIT (cycle 4 at default).
REQ-028 mem_sel SHALL never take the value 3'b111 or the values 3'b001..3'b011.

Reset
REQ-029 reset high at an edge SHALL force state IDLE and set mem_sel = 0, epc_wr = 0, pc_wr = 0, busy = 0, epc_out = 0, pc_out = 0, exc_cause = 0 and the wait counter to 0.
REQ-030 reset SHALL take precedence over any event and over any state, including mid-sequence; no pc_wr or epc_wr SHALL be issued for the aborted sequence.

Verification
REQ-031 exc_overflow pulsed 1 cycle with pc_in = 32'h40 and mem_rdata[7:0] = 8'h8C -> epc_wr in cycle 1 with epc_out = 32'h3C; mem_sel = 3'b101 in cycles 1-3; pc_wr in cycle 4 with pc_out = 32'h8C; exc_cause = 2'b10.
REQ-032 exc_opcode and exc_div0 raised together -> mem_sel = 3'b100, exc_cause = 2'b01, and exactly one sequence occurs.
REQ-033 exc_div0 held high continuously -> back-to-back sequences with one IDLE cycle between them; each sequence has exactly one epc_wr pulse and one pc_wr pulse.
REQ-034 reset asserted in the second WAIT cycle -> the next cycle is IDLE with all outputs zero, and pc_wr never rises.
REQ-035 pc_in = 0 with exc_opcode -> epc_out = 32'hFFFFFFFC.
REQ-036 MEM_WAIT = 1 and MEM_WAIT = 7 builds -> pc_wr occurs in cycle 3 and cycle 9 respectively, and mem_sel holds the vector for MEM_WAIT+1 cycles.

Source files
------------

// File: rtl/exception_ctrl.sv
// Exception sequencer: latches the winning exception cause and return address, fetches the
// handler byte from the vector table after MEM_WAIT read cycles, then loads it into the PC.
module exception_ctrl #(
    parameter int MEM_WAIT = 2    // memory read wait cycles, legal range 1..7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  mem_sel,
    output logic        epc_wr,
    output logic [31:0] epc_out,
    output logic        pc_wr,
    output logic [31:0] pc_out,
    output logic [1:0]  exc_cause,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SAVE  = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_wait_cnt;
    logic [31:0] r_epc;
    logic [31:0] r_pc;
    logic [1:0]  r_cause;
    logic        w_event;
    logic [1:0]  w_cause;
    logic [2:0]  w_vector;
    logic        w_unused_rdata;

    // Only the vector byte of the memory word is used.
    assign w_unused_rdata = &{1'b0, mem_rdata[31:8]};

    assign w_event = exc_opcode | exc_overflow | exc_div0;

    // Fixed priority: opcode > overflow > div0.
    always_comb begin
        w_cause = 2'b00;
        if (exc_opcode)
            w_cause = 2'b01;
        else if (exc_overflow)
            w_cause = 2'b10;
        else if (exc_div0)
            w_cause = 2'b11;
    end

    // Vector table selector for the latched cause; unused codes fall back to 3'b000.
    always_comb begin
        case (r_cause)
            2'b01:   w_vector = 3'b100;
            2'b10:   w_vector = 3'b101;
            2'b11:   w_vector = 3'b110;
            default: w_vector = 3'b000;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_event) w_state_next = S_SAVE;
            S_SAVE:  w_state_next = S_WAIT;
            S_WAIT:  if (r_wait_cnt == 3'd0) w_state_next = S_WRITE;
            S_WRITE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath registers: cause/EPC latched on entry, handler address on the last wait edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= 3'd0;
            r_epc      <= 32'd0;
            r_pc       <= 32'd0;
            r_cause    <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_event) begin
                        r_epc   <= pc_in - 32'd4;
                        r_cause <= w_cause;
                    end
                end
                S_SAVE: r_wait_cnt <= WAIT_LOAD;
                S_WAIT: begin
                    if (r_wait_cnt == 3'd0)
                        r_pc <= {24'b0, mem_rdata[7:0]};
                    else
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Output decode from state only
    always_comb begin
        mem_sel = 3'b000;
        epc_wr  = 1'b0;
        pc_wr   = 1'b0;
        busy    = 1'b1;
        case (r_state)
            S_IDLE:  busy = 1'b0;
            S_SAVE: begin
                epc_wr  = 1'b1;
                mem_sel = w_vector;
            end
            S_WAIT:  mem_sel = w_vector;
            S_WRITE: pc_wr = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign epc_out   = r_epc;
    assign pc_out    = r_pc;
    assign exc_cause = r_cause;

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: three instances (MEM_WAIT 1, 2, 7) share one stimulus stream and
// are checked against a scoreboard of expected sequences.
module tb_exception_ctrl;

    localparam int N_DUT = 3;

    function automatic int mw_of(input int d);
        case (d)
            0:       return 1;
            1:       return 2;
            default: return 7;
        endcase
    endfunction

    logic        clk;
    logic        reset;
    logic        exc_opcode;
    logic        exc_overflow;
    logic        exc_div0;
    logic [31:0] pc_in;
    logic [31:0] mem_rdata;

    logic [2:0]  mem_sel   [N_DUT];
    logic        epc_wr    [N_DUT];
    logic [31:0] epc_out   [N_DUT];
    logic        pc_wr     [N_DUT];
    logic [31:0] pc_out    [N_DUT];
    logic [1:0]  exc_cause [N_DUT];
    logic        busy      [N_DUT];

    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
        exception_ctrl #(.MEM_WAIT(mw_of(gi))) u_dut (
            .clk          (clk),
            .reset        (reset),
            .exc_opcode   (exc_opcode),
            .exc_overflow (exc_overflow),
            .exc_div0     (exc_div0),
            .pc_in        (pc_in),
            .mem_rdata    (mem_rdata),
            .mem_sel      (mem_sel[gi]),
            .epc_wr       (epc_wr[gi]),
            .epc_out      (epc_out[gi]),
            .pc_wr        (pc_wr[gi]),
            .pc_out       (pc_out[gi]),
            .exc_cause    (exc_cause[gi]),
            .busy         (busy[gi])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    // Expected sequence: start = cycle count when the event is driven (sampled at the next edge).
    typedef struct {
        int          start;
        logic [2:0]  mask;
        logic [1:0]  cause;
        logic [2:0]  sel;
        logic [31:0] epc;
        logic [31:0] pc;
    } rec_t;

    typedef struct {
        logic        opc;
        logic        ovf;
        logic        dz;
        logic [31:0] pin;
        logic [31:0] rdata;
        logic [1:0]  cause;
        logic [2:0]  sel;
        logic [31:0] epc;
        logic [31:0] pc;
    } vec_t;

    rec_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         mon_idx  [N_DUT];
    int         sel_cnt  [N_DUT];
    int         epc_cnt  [N_DUT];
    int         epc_cyc  [N_DUT];
    int         ill_cnt  [N_DUT];
    int         pcwr_cnt [N_DUT];
    logic [2:0] sel_val  [N_DUT];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic monitor_step();
        rec_t r;
        for (int d = 0; d < N_DUT; d++) begin
            if (reset) begin
                sel_cnt[d] = 0;
                epc_cnt[d] = 0;
                sel_val[d] = 3'b000;
            end else begin
                if (mem_sel[d] inside {3'd1, 3'd2, 3'd3, 3'd7}) ill_cnt[d]++;
                if (mem_sel[d] != 3'b000) begin
                    sel_cnt[d]++;
                    sel_val[d] = mem_sel[d];
                end
                if (epc_wr[d]) begin
                    epc_cnt[d]++;
                    epc_cyc[d] = cyc;
                end
                if (pc_wr[d]) begin
                    pcwr_cnt[d]++;
                    while (mon_idx[d] < exp_q.size() && !exp_q[mon_idx[d]].mask[d]) mon_idx[d]++;
                    if (mon_idx[d] >= exp_q.size()) begin
                        n_checks++;
                        $display("FAIL dut%0d_unexpected_pc_wr: pc_wr at cycle %0d, required none", d, cyc);
                    end else begin
                        r = exp_q[mon_idx[d]];
                        mon_idx[d]++;
                        check($sformatf("dut%0d_seq_data", d),
                              {exc_cause[d], sel_val[d], epc_out[d], pc_out[d]},
                              {r.cause, r.sel, r.epc, r.pc});
                        check($sformatf("dut%0d_seq_timing", d),
                              {32'(cyc - r.start), 32'(epc_cyc[d] - r.start), 32'(sel_cnt[d]), 32'(epc_cnt[d])},
                              {32'(2 + mw_of(d)), 32'd1, 32'(mw_of(d) + 1), 32'd1});
                        $display("seq dut%0d MEM_WAIT=%0d cause=%0d sel=%0d epc=%h pc=%h pc_wr_cycle=%0d",
                                 d, mw_of(d), exc_cause[d], sel_val[d], epc_out[d], pc_out[d], cyc - r.start);
                    end
                    sel_cnt[d] = 0;
                    epc_cnt[d] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor_step();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((busy[0] | busy[1] | busy[2]) && n < 80);
        if (busy[0] | busy[1] | busy[2]) begin
            n_checks++;
            $display("FAIL %s_timeout: busy still high after %0d cycles, required idle", tag, n);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < N_DUT; d++)
            check($sformatf("%s_dut%0d", tag, d),
                  {mem_sel[d], epc_wr[d], pc_wr[d], busy[d], epc_out[d], pc_out[d], exc_cause[d]},
                  '0);
    endtask

    initial begin
        vec_t vt [7];
        int   nexp;
        int   start;

        vt[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h1234_568C, 2'b10, 3'b101, 32'h0000_003C, 32'h0000_008C};
        vt[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'hFFFF_FF11, 2'b01, 3'b100, 32'h0000_0FFC, 32'h0000_0011};
        vt[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_00FD, 2'b01, 3'b100, 32'hFFFF_FFFC, 32'h0000_00FD};
        vt[3] = '{1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'hABCD_EF00, 2'b11, 3'b110, 32'h1234_5674, 32'h0000_0000};
        vt[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_007F, 2'b10, 3'b101, 32'h0000_0000, 32'h0000_007F};
        vt[5] = '{1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'h5A5A_5AA5, 2'b01, 3'b100, 32'h7FFF_FFFC, 32'h0000_00A5};
        vt[6] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_00FF, 2'b01, 3'b100, 32'hFFFF_FFFB, 32'h0000_00FF};

        for (int d = 0; d < N_DUT; d++) begin
            mon_idx[d] = 0; sel_cnt[d] = 0; epc_cnt[d] = 0; epc_cyc[d] = 0;
            ill_cnt[d] = 0; pcwr_cnt[d] = 0; sel_val[d] = 3'b000;
        end

        // Reset wins over events held high.
        reset = 1'b1; exc_opcode = 1'b1; exc_overflow = 1'b1; exc_div0 = 1'b1;
        pc_in = 32'hDEAD_BEEF; mem_rdata = 32'hFFFF_FFFF;
        repeat (3) tick();
        check_all_zero("reset_state");
        reset = 1'b0; exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
        repeat (2) tick();

        // Single-pulse events, one table row per sequence.
        for (int i = 0; i < 7; i++) begin
            pc_in = vt[i].pin; mem_rdata = vt[i].rdata;
            exc_opcode = vt[i].opc; exc_overflow = vt[i].ovf; exc_div0 = vt[i].dz;
            exp_q.push_back('{cyc, 3'b111, vt[i].cause, vt[i].sel, vt[i].epc, vt[i].pc});
            tick();
            exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
            wait_idle($sformatf("vec%0d", i));
            tick();
            for (int d = 0; d < N_DUT; d++)
                check($sformatf("vec%0d_hold_dut%0d", i, d),
                      {exc_cause[d], epc_out[d], pc_out[d]}, {vt[i].cause, vt[i].epc, vt[i].pc});
        end

        // A new event raised mid-sequence must be ignored.
        pc_in = 32'h0000_0100; mem_rdata = 32'h0000_0042;
        exc_overflow = 1'b1;
        exp_q.push_back('{cyc, 3'b111, 2'b10, 3'b101, 32'h0000_00FC, 32'h0000_0042});
        tick();
        exc_overflow = 1'b0;
        tick();
        exc_opcode = 1'b1;
        tick();
        exc_opcode = 1'b0;
        wait_idle("busy_ignore");
        repeat (2) tick();
        for (int d = 0; d < N_DUT; d++)
            check($sformatf("busy_ignore_cause_dut%0d", d), {exc_cause[d], pc_out[d]}, {2'b10, 32'h0000_0042});

        // div0 held for 20 cycles: back-to-back sequences with one IDLE cycle (period 3+MEM_WAIT).
        pc_in = 32'h0000_2000; mem_rdata = 32'h0000_0077;
        exc_div0 = 1'b1;
        start = cyc;
        for (int d = 0; d < N_DUT; d++)
            for (int k = 0; k * (3 + mw_of(d)) < 20; k++)
                exp_q.push_back('{start + k * (3 + mw_of(d)), 3'(1 << d), 2'b11, 3'b110, 32'h0000_1FFC, 32'h0000_0077});
        repeat (20) tick();
        exc_div0 = 1'b0;
        wait_idle("held_div0");
        tick();

        // Reset during cycle 3 (second WAIT at MEM_WAIT=2): only the MEM_WAIT=1 instance completes.
        pc_in = 32'h0000_0200; mem_rdata = 32'h0000_0033;
        exc_div0 = 1'b1;
        exp_q.push_back('{cyc, 3'b001, 2'b11, 3'b110, 32'h0000_01FC, 32'h0000_0033});
        tick();
        exc_div0 = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_all_zero("mid_reset");
        reset = 1'b0;
        repeat (12) tick();
        for (int d = 0; d < N_DUT; d++)
            check($sformatf("after_reset_idle_dut%0d", d), {busy[d], pc_out[d]}, {1'b0, 32'h0});

        // Totals: every expected sequence seen exactly once, no stray pc_wr, no illegal selector.
        for (int d = 0; d < N_DUT; d++) begin
            nexp = 0;
            foreach (exp_q[j]) if (exp_q[j].mask[d]) nexp++;
            check($sformatf("pc_wr_count_dut%0d", d), 128'(pcwr_cnt[d]), 128'(nexp));
            check($sformatf("illegal_sel_dut%0d", d), 128'(ill_cnt[d]), 128'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
